// File: rtl/cpu_pkg.sv
// Shared types and constants for the four-way memory port arbiter.
package cpu_pkg;

  // Arbiter FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  // Requester select code; also the steering code for the lane muxes.
  typedef logic [1:0] sel_t;

  localparam sel_t REQ_IF  = 2'd0;
  localparam sel_t REQ_LS  = 2'd1;
  localparam sel_t REQ_DBG = 2'd2;
  localparam sel_t REQ_DMA = 2'd3;

endpackage

// File: rtl/mem_port_arbiter_4_if.sv
// Requester and memory-side signal bundle of the arbiter.
interface mem_port_arbiter_4_if #(
  parameter int unsigned DATA_W = 32
);
  logic [3:0]          req;
  logic [3:0]          we;
  logic [4*DATA_W-1:0] addr_in;
  logic [4*DATA_W-1:0] wdata_in;
  logic [DATA_W-1:0]   mem_rdata;
  logic                mem_en;
  logic                mem_we;
  logic [DATA_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [3:0]          grant;
  logic [1:0]          grant_sel;
  logic [3:0]          ack;
  logic [DATA_W-1:0]   rdata;

  // Requesters plus memory model side.
  modport master (
    output req, we, addr_in, wdata_in, mem_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, grant, grant_sel, ack, rdata
  );

  // Arbiter side.
  modport slave (
    input  req, we, addr_in, wdata_in, mem_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, grant, grant_sel, ack, rdata
  );
endinterface

// File: rtl/mem_port_arbiter_4_rr_pick_4.sv
// Round-robin picker: first set request scanning ptr, ptr+1, ... modulo 4.
module rr_pick_4
  import cpu_pkg::*;
(
  input  logic [3:0] req,
  input  sel_t       ptr,
  output logic       found,
  output sel_t       idx
);

  sel_t cand;

  // Scan from the farthest offset down so the closest-to-ptr request wins.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr + sel_t'(i);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter_4.sv
// Round-robin arbiter sharing one fixed-latency memory port among four requesters.
module mem_port_arbiter_4
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input logic                 clk,
  input logic                 rst,
  mem_port_arbiter_4_if.slave bus
);

  localparam logic [3:0] CntInit = 4'(MEM_LAT - 1);

  state_e              state_q, state_d;
  sel_t                rr_ptr_q, rr_ptr_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [3:0]          grant_q, grant_d;
  sel_t                grant_sel_q, grant_sel_d;
  logic [3:0]          ack_q, ack_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [DATA_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                pick_found;
  sel_t                pick_idx;

  // 4:1 lane select out of a flattened bus.
  function automatic logic [DATA_W-1:0] lane_sel(input logic [4*DATA_W-1:0] flat,
                                                 input sel_t s);
    logic [DATA_W-1:0] v;
    unique case (s)
      2'd0:    v = flat[0*DATA_W +: DATA_W];
      2'd1:    v = flat[1*DATA_W +: DATA_W];
      2'd2:    v = flat[2*DATA_W +: DATA_W];
      default: v = flat[3*DATA_W +: DATA_W];
    endcase
    return v;
  endfunction

  rr_pick_4 u_pick (
    .req   (bus.req),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Next-state and registered-output logic; everything holds unless a state acts on it.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    grant_sel_d = grant_sel_q;
    ack_d       = ack_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        ack_d = 4'b0000;
        if (pick_found) begin
          grant_sel_d = pick_idx;
          grant_d     = 4'b0001 << pick_idx;
          mem_en_d    = 1'b1;
          mem_we_d    = bus.we[pick_idx];
          // Port values latched here; later lane changes are ignored.
          mem_addr_d  = lane_sel(bus.addr_in, pick_idx);
          mem_wdata_d = lane_sel(bus.wdata_in, pick_idx);
          cnt_d       = CntInit;
          state_d     = ST_BUSY;
        end else begin
          grant_d     = 4'b0000;
          grant_sel_d = 2'd0;
          mem_en_d    = 1'b0;
          mem_we_d    = 1'b0;
        end
      end
      ST_BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rdata_d  = bus.mem_rdata;
          ack_d    = grant_q;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          // Served requester drops to lowest priority.
          rr_ptr_d = grant_sel_q + 2'd1;
          state_d  = ST_ACK;
        end
      end
      ST_ACK: begin
        ack_d       = 4'b0000;
        grant_d     = 4'b0000;
        grant_sel_d = 2'd0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset; reset aborts any transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= 2'd0;
      cnt_q       <= 4'd0;
      grant_q     <= 4'b0000;
      grant_sel_q <= 2'd0;
      ack_q       <= 4'b0000;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      grant_sel_q <= grant_sel_d;
      ack_q       <= ack_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.grant_sel = grant_sel_q;
  assign bus.ack       = ack_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rdata     = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter_4.sv
// Bench for mem_port_arbiter_4: two instances (MEM_LAT 2 and 1) share stimulus and are
// compared every cycle against a transaction-age model, plus directed literal checks.
module tb_mem_port_arbiter_4;
  import cpu_pkg::*;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req;
  logic [3:0]    we;
  logic [DW-1:0] addr_lane  [4];
  logic [DW-1:0] wdata_lane [4];
  logic [DW-1:0] mem_rdata;
  logic          chk_en = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_4_if #(.DATA_W(DW)) bus0 ();
  mem_port_arbiter_4_if #(.DATA_W(DW)) bus1 ();

  assign bus0.req       = req;
  assign bus0.we        = we;
  assign bus0.addr_in   = {addr_lane[3], addr_lane[2], addr_lane[1], addr_lane[0]};
  assign bus0.wdata_in  = {wdata_lane[3], wdata_lane[2], wdata_lane[1], wdata_lane[0]};
  assign bus0.mem_rdata = mem_rdata;
  assign bus1.req       = req;
  assign bus1.we        = we;
  assign bus1.addr_in   = {addr_lane[3], addr_lane[2], addr_lane[1], addr_lane[0]};
  assign bus1.wdata_in  = {wdata_lane[3], wdata_lane[2], wdata_lane[1], wdata_lane[0]};
  assign bus1.mem_rdata = mem_rdata;

  mem_port_arbiter_4 #(.DATA_W(DW), .MEM_LAT(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  mem_port_arbiter_4 #(.DATA_W(DW), .MEM_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Model: a transaction is described by its age in cycles since the grant edge.
  // Ages 0..L-1 drive the port, age L is the ack cycle, age L+1 is the idle gap.
  int          m_age   [2];
  int          m_lat   [2];
  logic [1:0]  m_ptr   [2];
  logic [3:0]  m_grant [2];
  logic [1:0]  m_sel   [2];
  logic        m_en    [2];
  logic        m_we    [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [3:0]  m_ack   [2];
  logic [31:0] m_rdata [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_step(input int k);
    int p;
    int g;
    bit found;
    if (rst) begin
      m_age[k] = -1; m_ptr[k] = 2'd0; m_grant[k] = 4'd0; m_sel[k] = 2'd0;
      m_en[k] = 1'b0; m_we[k] = 1'b0; m_addr[k] = '0; m_wdata[k] = '0;
      m_ack[k] = 4'd0; m_rdata[k] = '0;
    end else if (m_age[k] < 0 || m_age[k] == m_lat[k] + 1) begin
      p = int'(m_ptr[k]);
      found = 1'b0;
      g = 0;
      for (int j = 0; j < 4; j++) begin
        if (!found && req[(p + j) % 4]) begin
          found = 1'b1;
          g = (p + j) % 4;
        end
      end
      m_ack[k] = 4'd0;
      if (found) begin
        m_age[k] = 0; m_sel[k] = 2'(g); m_grant[k] = 4'(1 << g);
        m_en[k] = 1'b1; m_we[k] = we[g]; m_addr[k] = addr_lane[g]; m_wdata[k] = wdata_lane[g];
      end else begin
        m_age[k] = -1; m_grant[k] = 4'd0; m_sel[k] = 2'd0; m_en[k] = 1'b0; m_we[k] = 1'b0;
      end
    end else begin
      m_age[k] = m_age[k] + 1;
      if (m_age[k] == m_lat[k]) begin
        m_ack[k] = m_grant[k]; m_en[k] = 1'b0; m_we[k] = 1'b0; m_rdata[k] = mem_rdata;
        m_ptr[k] = m_sel[k] + 2'd1;
      end else if (m_age[k] == m_lat[k] + 1) begin
        m_ack[k] = 4'd0; m_grant[k] = 4'd0; m_sel[k] = 2'd0;
      end
    end
  endtask

  task automatic cmp(input int k, input logic [3:0] g, input logic [1:0] s, input logic en,
                     input logic wr, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] ak, input logic [31:0] rd);
    check($sformatf("lat%0d grant", m_lat[k]), 32'(g), 32'(m_grant[k]));
    check($sformatf("lat%0d grant_sel", m_lat[k]), 32'(s), 32'(m_sel[k]));
    check($sformatf("lat%0d mem_en", m_lat[k]), 32'(en), 32'(m_en[k]));
    check($sformatf("lat%0d mem_we", m_lat[k]), 32'(wr), 32'(m_we[k]));
    check($sformatf("lat%0d mem_addr", m_lat[k]), a, m_addr[k]);
    check($sformatf("lat%0d mem_wdata", m_lat[k]), wd, m_wdata[k]);
    check($sformatf("lat%0d ack", m_lat[k]), 32'(ak), 32'(m_ack[k]));
    check($sformatf("lat%0d rdata", m_lat[k]), rd, m_rdata[k]);
  endtask

  initial begin
    m_lat[0] = 2;
    m_lat[1] = 1;
    for (int k = 0; k < 2; k++) m_age[k] = -1;
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) model_step(k);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        cmp(0, bus0.grant, bus0.grant_sel, bus0.mem_en, bus0.mem_we, bus0.mem_addr,
            bus0.mem_wdata, bus0.ack, bus0.rdata);
        cmp(1, bus1.grant, bus1.grant_sel, bus1.mem_en, bus1.mem_we, bus1.mem_addr,
            bus1.mem_wdata, bus1.ack, bus1.rdata);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  int          n_cap;
  logic [1:0]  cap_sel [5];
  int          cap_cyc [5];
  logic        prev_en;
  int          cnt_a;
  int          cnt_b;

  initial begin
    rst = 1'b1; req = 4'd0; we = 4'd0; mem_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      addr_lane[i] = '0;
      wdata_lane[i] = '0;
    end
    tick(2);
    chk_en = 1'b1;

    // Test 1: single read from requester 1.
    do_reset();
    check("t1 reset grant", 32'(bus0.grant), 32'h0);
    check("t1 reset mem_en", 32'(bus0.mem_en), 32'h0);
    check("t1 reset rdata", bus0.rdata, 32'h0);
    req = 4'b0010; we = 4'b0000; addr_lane[1] = 32'h0000_0040; mem_rdata = 32'hDEAD_BEEF;
    tick(1);
    check("t1 grant_sel", 32'(bus0.grant_sel), 32'd1);
    check("t1 grant", 32'(bus0.grant), 32'h2);
    check("t1 mem_addr", bus0.mem_addr, 32'h40);
    check("t1 mem_en c0", 32'(bus0.mem_en), 32'd1);
    tick(1);
    check("t1 mem_en c1", 32'(bus0.mem_en), 32'd1);
    check("t1 ack early", 32'(bus0.ack), 32'h0);
    tick(1);
    check("t1 ack", 32'(bus0.ack), 32'h2);
    check("t1 rdata", bus0.rdata, 32'hDEAD_BEEF);
    check("t1 mem_en off", 32'(bus0.mem_en), 32'd0);
    req = 4'b1111;
    tick(1);
    check("t1 idle grant", 32'(bus0.grant), 32'h0);
    tick(1);
    check("t1 next after ptr", 32'(bus0.grant_sel), 32'd2);

    // Test 2: all requesting from reset.
    req = 4'b1111;
    do_reset();
    n_cap = 0;
    prev_en = 1'b0;
    for (int c = 0; c < 22; c++) begin
      tick(1);
      if (bus0.mem_en && !prev_en && n_cap < 5) begin
        cap_sel[n_cap] = bus0.grant_sel;
        cap_cyc[n_cap] = c;
        n_cap++;
      end
      prev_en = bus0.mem_en;
    end
    check("t2 grant count", 32'(n_cap), 32'd5);
    for (int i = 0; i < n_cap; i++) begin
      check("t2 grant order", 32'(cap_sel[i]), 32'(i % 4));
      if (i > 0) check("t2 grant spacing", 32'(cap_cyc[i] - cap_cyc[i-1]), 32'd4);
    end

    // Test 3: write from requester 3.
    req = 4'b0000;
    do_reset();
    req = 4'b1000; we = 4'b1000; wdata_lane[3] = 32'h1234_5678; addr_lane[3] = 32'h100;
    cnt_a = 0; cnt_b = 0;
    for (int c = 0; c < 8; c++) begin
      tick(1);
      if (c == 0) begin
        check("t3 mem_addr", bus0.mem_addr, 32'h100);
        req = 4'b0000;
      end
      if (bus0.mem_we && bus0.mem_wdata == 32'h1234_5678) cnt_a++;
      if (bus0.ack[3]) cnt_b++;
    end
    check("t3 mem_we cycles", 32'(cnt_a), 32'd2);
    check("t3 ack3 pulses", 32'(cnt_b), 32'd1);
    we = 4'b0000;

    // Test 4: requester 0 drops req and changes address after grant.
    do_reset();
    addr_lane[0] = 32'h0000_00A0; req = 4'b0001;
    tick(1);
    req = 4'b0000; addr_lane[0] = 32'h000B_EEF0;
    tick(1);
    check("t4 mem_addr latched", bus0.mem_addr, 32'h0000_00A0);
    cnt_a = 0; cnt_b = 0; prev_en = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (bus0.ack[0]) cnt_a++;
      tick(1);
      if (bus0.mem_en && !prev_en) cnt_b++;
      prev_en = bus0.mem_en;
    end
    check("t4 ack0 pulses", 32'(cnt_a), 32'd1);
    check("t4 regrants", 32'(cnt_b), 32'd0);

    // Test 5: reset in the second BUSY cycle.
    do_reset();
    req = 4'b0010;
    tick(1);
    req = 4'b0000;
    tick(3);
    req = 4'b0100;
    tick(1);
    check("t5 grant_sel", 32'(bus0.grant_sel), 32'd2);
    tick(1);
    rst = 1'b1;
    tick(1);
    check("t5 mem_en", 32'(bus0.mem_en), 32'd0);
    check("t5 grant", 32'(bus0.grant), 32'h0);
    check("t5 ack", 32'(bus0.ack), 32'h0);
    rst = 1'b0; req = 4'b0101;
    tick(1);
    check("t5 first after reset", 32'(bus0.grant_sel), 32'd0);
    req = 4'b0000;
    tick(4);

    // Test 6: MEM_LAT=1 instance.
    do_reset();
    req = 4'b0100; mem_rdata = 32'h1111_1111;
    tick(1);
    check("t6 grant_sel", 32'(bus1.grant_sel), 32'd2);
    check("t6 mem_en", 32'(bus1.mem_en), 32'd1);
    mem_rdata = 32'hCAFE_F00D; req = 4'b0000;
    tick(1);
    check("t6 ack", 32'(bus1.ack), 32'h4);
    check("t6 mem_en off", 32'(bus1.mem_en), 32'd0);
    check("t6 rdata", bus1.rdata, 32'hCAFE_F00D);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      tick(1);
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      we = 4'($urandom);
      addr_lane[$urandom_range(0, 3)] = $urandom;
      wdata_lane[$urandom_range(0, 3)] = $urandom;
      mem_rdata = $urandom;
    end
    rst = 1'b0;
    req = 4'b0000;
    tick(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
